// File: rtl/vec_pkg.sv
// Shared opcode/state types and the opcode legality helper for the vector issue controller.
package vec_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_MUL    = 4'b0010,
        OP_ADDS   = 4'b0100,
        OP_SUBS   = 4'b0101,
        OP_MULS   = 4'b0110,
        OP_READ   = 4'b1000,
        OP_WRITE  = 4'b1001,
        OP_MATMUL = 4'b1111
    } vec_op_e;

    typedef enum logic [1:0] {
        s_IDLE  = 2'd0,
        s_ISSUE = 2'd1,
        s_BUSY  = 2'd2,
        s_RESP  = 2'd3
    } vec_state_e;

    function automatic logic vec_op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL,
            OP_ADDS, OP_SUBS, OP_MULS,
            OP_READ, OP_WRITE, OP_MATMUL: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vec_rr_arb.sv
// Round-robin arbiter: the priority pointer moves past the winner only when advance_i
// reports that the grant was actually taken.
module vec_rr_arb #(
    parameter  int reqs_p   = 2,
    localparam int idx_w_lp = $clog2(reqs_p)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [reqs_p-1:0]   req_i,
    input  logic                advance_i,
    output logic [reqs_p-1:0]   grant_o,
    output logic [idx_w_lp-1:0] grant_idx_o,
    output logic                grant_v_o
);

    logic [idx_w_lp-1:0] ptr_r;
    logic [idx_w_lp-1:0] idx;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_v_o   = 1'b0;
        idx         = '0;
        for (int k = 0; k < reqs_p; k++) begin
            idx = idx_w_lp'((int'(ptr_r) + k) % reqs_p);
            if (!grant_v_o && req_i[idx]) begin
                grant_v_o    = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ptr_r <= '0;
        end else if (advance_i && grant_v_o) begin
            ptr_r <= (grant_idx_o == idx_w_lp'(reqs_p - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/vec_issue_ctrl.sv
// Command scheduler in front of the vector unit: arbitrates requesters, screens commands,
// holds the accepted command on the unit pins and returns the response to its owner.
module vec_issue_ctrl
    import vec_pkg::*;
#(
    parameter  int els_p           = 12,
    parameter  int vlen_p          = 4,
    parameter  int vdw_p           = 6,
    parameter  int reqs_p          = 2,
    localparam int v_addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p),
    localparam int vw_lp           = vlen_p * vdw_p,
    localparam int owner_w_lp      = $clog2(reqs_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,

    input  logic [reqs_p-1:0]                      req_v_i,
    output logic [reqs_p-1:0]                      req_ready_o,
    input  logic [reqs_p-1:0][3:0]                 req_op_i,
    input  logic [reqs_p-1:0][v_addr_width_lp-1:0] req_addrA_i,
    input  logic [reqs_p-1:0][v_addr_width_lp-1:0] req_addrB_i,
    input  logic [reqs_p-1:0][v_addr_width_lp-1:0] req_addrD_i,
    input  logic [reqs_p-1:0][vdw_p-1:0]           req_scalar_i,
    input  logic [reqs_p-1:0][vw_lp-1:0]           req_w_data_i,

    output logic [reqs_p-1:0]                      resp_v_o,
    output logic [vw_lp-1:0]                       resp_data_o,
    output logic                                   resp_err_o,
    input  logic [reqs_p-1:0]                      resp_yumi_i,

    output logic [3:0]                             vu_op_o,
    output logic [v_addr_width_lp-1:0]             vu_addrA_o,
    output logic [v_addr_width_lp-1:0]             vu_addrB_o,
    output logic [v_addr_width_lp-1:0]             vu_addrD_o,
    output logic [vdw_p-1:0]                       vu_scalar_o,
    output logic [vw_lp-1:0]                       vu_w_data_o,
    output logic                                   vu_v_o,
    input  logic                                   vu_ready_i,
    input  logic                                   vu_done_i,
    input  logic                                   vu_v_i,
    input  logic [vw_lp-1:0]                       vu_r_data_i,
    output logic                                   vu_yumi_o
);

    localparam int aw_lp = v_addr_width_lp + 1;

    vec_state_e                state_r, state_n;
    logic [reqs_p-1:0]         grant;
    logic [owner_w_lp-1:0]     grant_idx, owner_r;
    logic                      grant_v, xfer;
    logic                      err_r, done_seen_r, done_now, is_read, capture;
    logic [vw_lp-1:0]          data_r;

    logic [3:0]                sel_op;
    logic [aw_lp-1:0]          sel_a, sel_b, sel_d;
    logic                      a_ok, b_ok, d_ok, a_span_ok, b_span_ok, d_span_ok;
    logic                      addr_ok, cmd_legal;

    vec_rr_arb #(.reqs_p(reqs_p)) arb (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .req_i       (req_v_i),
        .advance_i   (xfer),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_v_o   (grant_v)
    );

    assign xfer = (state_r == s_IDLE) && grant_v;

    // Screen the granted command before it is accepted; addresses are widened one bit
    // so the matmul span sums cannot wrap.
    always_comb begin
        sel_op    = req_op_i[grant_idx];
        sel_a     = {1'b0, req_addrA_i[grant_idx]};
        sel_b     = {1'b0, req_addrB_i[grant_idx]};
        sel_d     = {1'b0, req_addrD_i[grant_idx]};
        a_ok      = sel_a < aw_lp'(els_p);
        b_ok      = sel_b < aw_lp'(els_p);
        d_ok      = sel_d < aw_lp'(els_p);
        a_span_ok = (sel_a + aw_lp'(vlen_p - 1)) < aw_lp'(els_p);
        b_span_ok = (sel_b + aw_lp'(vlen_p - 1)) < aw_lp'(els_p);
        d_span_ok = (sel_d + aw_lp'(vlen_p - 1)) < aw_lp'(els_p);
        addr_ok   = 1'b0;
        case (sel_op)
            OP_READ, OP_WRITE:        addr_ok = d_ok;
            OP_ADDS, OP_SUBS, OP_MULS: addr_ok = a_ok && d_ok;
            OP_MATMUL:                addr_ok = a_span_ok && b_span_ok && d_span_ok;
            default:                  addr_ok = a_ok && b_ok && d_ok;
        endcase
        cmd_legal = vec_op_legal(sel_op) && addr_ok;
    end

    // A done pulse may precede read data; remember it so the data is still taken.
    assign is_read  = (vu_op_o == OP_READ);
    assign done_now = vu_done_i || done_seen_r;
    assign capture  = (state_r == s_BUSY) && done_now && (!is_read || vu_v_i);

    always_comb begin
        state_n     = state_r;
        req_ready_o = '0;
        resp_v_o    = '0;
        vu_v_o      = 1'b0;
        vu_yumi_o   = 1'b0;
        case (state_r)
            s_IDLE: begin
                req_ready_o = grant;
                if (xfer) state_n = cmd_legal ? s_ISSUE : s_RESP;
            end
            s_ISSUE: begin
                vu_v_o = 1'b1;
                if (vu_ready_i) state_n = s_BUSY;
            end
            s_BUSY: begin
                vu_yumi_o = is_read && done_now && vu_v_i;
                if (capture) state_n = s_RESP;
            end
            s_RESP: begin
                resp_v_o[owner_r] = 1'b1;
                if (resp_yumi_i[owner_r]) state_n = s_IDLE;
            end
            default: state_n = s_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r     <= s_IDLE;
            owner_r     <= '0;
            vu_op_o     <= '0;
            vu_addrA_o  <= '0;
            vu_addrB_o  <= '0;
            vu_addrD_o  <= '0;
            vu_scalar_o <= '0;
            vu_w_data_o <= '0;
            err_r       <= 1'b0;
            data_r      <= '0;
            done_seen_r <= 1'b0;
        end else begin
            state_r <= state_n;
            if (xfer) begin
                owner_r     <= grant_idx;
                vu_op_o     <= req_op_i[grant_idx];
                vu_addrA_o  <= req_addrA_i[grant_idx];
                vu_addrB_o  <= req_addrB_i[grant_idx];
                vu_addrD_o  <= req_addrD_i[grant_idx];
                vu_scalar_o <= req_scalar_i[grant_idx];
                vu_w_data_o <= req_w_data_i[grant_idx];
                err_r       <= !cmd_legal;
                data_r      <= '0;
                done_seen_r <= 1'b0;
            end
            if (state_r == s_BUSY) begin
                if (vu_done_i) done_seen_r <= 1'b1;
                if (capture) begin
                    data_r      <= is_read ? vu_r_data_i : '0;
                    done_seen_r <= 1'b0;
                end
            end
            if (state_r == s_RESP && resp_yumi_i[owner_r]) err_r <= 1'b0;
        end
    end

    assign resp_err_o  = err_r;
    assign resp_data_o = data_r;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Scoreboard bench for vec_issue_ctrl with a small behavioural vector-unit model.
module tb_vec_issue_ctrl;
    import vec_pkg::*;

    localparam int els_p  = 12;
    localparam int vlen_p = 4;
    localparam int vdw_p  = 6;
    localparam int reqs_p = 2;
    localparam int aw     = 4;
    localparam int vw     = vlen_p * vdw_p;

    logic                         clk_i = 1'b0;
    logic                         reset_n_i;
    logic [reqs_p-1:0]            req_v_i;
    logic [reqs_p-1:0]            req_ready_o;
    logic [reqs_p-1:0][3:0]       req_op_i;
    logic [reqs_p-1:0][aw-1:0]    req_addrA_i, req_addrB_i, req_addrD_i;
    logic [reqs_p-1:0][vdw_p-1:0] req_scalar_i;
    logic [reqs_p-1:0][vw-1:0]    req_w_data_i;
    logic [reqs_p-1:0]            resp_v_o;
    logic [vw-1:0]                resp_data_o;
    logic                         resp_err_o;
    logic [reqs_p-1:0]            resp_yumi_i;
    logic [3:0]                   vu_op_o;
    logic [aw-1:0]                vu_addrA_o, vu_addrB_o, vu_addrD_o;
    logic [vdw_p-1:0]             vu_scalar_o;
    logic [vw-1:0]                vu_w_data_o;
    logic                         vu_v_o, vu_ready_i, vu_done_i, vu_v_i, vu_yumi_o;
    logic [vw-1:0]                vu_r_data_i;

    always #5 clk_i = ~clk_i;

    vec_issue_ctrl #(.els_p(els_p), .vlen_p(vlen_p), .vdw_p(vdw_p), .reqs_p(reqs_p)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .req_v_i      (req_v_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_addrA_i  (req_addrA_i),
        .req_addrB_i  (req_addrB_i),
        .req_addrD_i  (req_addrD_i),
        .req_scalar_i (req_scalar_i),
        .req_w_data_i (req_w_data_i),
        .resp_v_o     (resp_v_o),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .resp_yumi_i  (resp_yumi_i),
        .vu_op_o      (vu_op_o),
        .vu_addrA_o   (vu_addrA_o),
        .vu_addrB_o   (vu_addrB_o),
        .vu_addrD_o   (vu_addrD_o),
        .vu_scalar_o  (vu_scalar_o),
        .vu_w_data_o  (vu_w_data_o),
        .vu_v_o       (vu_v_o),
        .vu_ready_i   (vu_ready_i),
        .vu_done_i    (vu_done_i),
        .vu_v_i       (vu_v_i),
        .vu_r_data_i  (vu_r_data_i),
        .vu_yumi_o    (vu_yumi_o)
    );

    typedef struct {
        logic [reqs_p-1:0] owner;
        logic              err;
        logic [vw-1:0]     data;
        int                cyc;   // -1: any cycle, -2: cycle after unit done
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          yumi_cyc = -10;
    int          done_cyc = -10;
    int          bp = 0;

    logic [vw-1:0] mem [16];
    bit          u_busy = 1'b0;
    int          u_cnt = 0;
    int          u_lat = 1;
    logic [3:0]  u_op;
    logic [aw-1:0] u_addr;
    int          ready_block = 0;
    int          issues = 0;

    // One clock cycle: unit handshake before the edge, unit model and response monitor after it.
    task automatic step();
        exp_t e;
        int   want_c;
        if (vu_v_o === 1'b1 && vu_ready_i === 1'b1) begin
            u_busy = 1'b1;
            u_cnt  = u_lat;
            u_op   = vu_op_o;
            u_addr = vu_addrD_o;
            issues++;
            if (vu_op_o == OP_WRITE) mem[vu_addrD_o] = vu_w_data_o;
        end
        @(posedge clk_i);
        #1;
        cycle++;
        vu_done_i   = 1'b0;
        vu_v_i      = 1'b0;
        vu_r_data_i = '0;
        if (u_busy) begin
            if (u_cnt == 0) begin
                vu_done_i = 1'b1;
                done_cyc  = cycle;
                u_busy    = 1'b0;
                if (u_op == OP_READ) begin
                    vu_v_i      = 1'b1;
                    vu_r_data_i = mem[u_addr];
                end
            end else begin
                u_cnt--;
            end
        end
        vu_ready_i = (ready_block == 0);
        if (vu_v_o === 1'b1 && ready_block > 0) ready_block--;
        resp_yumi_i = '0;
        if (resp_v_o !== '0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: got resp_v_o=%b, required no response", resp_v_o);
            end else begin
                e = sb.pop_front();
                if (resp_v_o !== e.owner || resp_err_o !== e.err || resp_data_o !== e.data) begin
                    bad++;
                    $display("FAIL resp_fields: got v=%b err=%b data=%h, required v=%b err=%b data=%h",
                             resp_v_o, resp_err_o, resp_data_o, e.owner, e.err, e.data);
                end
                if (e.cyc != -1) begin
                    want_c = (e.cyc == -2) ? done_cyc + 1 : e.cyc;
                    total++;
                    if (cycle != want_c) begin
                        bad++;
                        $display("FAIL resp_latency: got cycle %0d, required cycle %0d", cycle, want_c);
                    end
                end
            end
            resp_yumi_i = resp_v_o;
            yumi_cyc    = cycle;
        end
        #1;
        if (vu_v_i) begin
            total++;
            if (vu_yumi_o !== 1'b1) begin
                bad++;
                $display("FAIL vu_yumi: got %b, required 1", vu_yumi_o);
            end
        end
    endtask

    task automatic send(input int idx, input logic [3:0] op, input logic [aw-1:0] a,
                        input logic [aw-1:0] b, input logic [aw-1:0] d, input logic [vdw_p-1:0] s,
                        input logic [vw-1:0] w, input logic exp_err, input logic [vw-1:0] exp_data);
        int   waited = 0;
        exp_t e;
        req_v_i[idx]      = 1'b1;
        req_op_i[idx]     = op;
        req_addrA_i[idx]  = a;
        req_addrB_i[idx]  = b;
        req_addrD_i[idx]  = d;
        req_scalar_i[idx] = s;
        req_w_data_i[idx] = w;
        #1;
        while (req_ready_o[idx] !== 1'b1 && waited < 50) begin
            step();
            #1;
            waited++;
        end
        if (waited >= 50) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: requester %0d got no grant, required one within 50 cycles", idx);
            req_v_i[idx] = 1'b0;
            return;
        end
        e.owner      = '0;
        e.owner[idx] = 1'b1;
        e.err        = exp_err;
        e.data       = exp_data;
        e.cyc        = exp_err ? cycle + 1 : -2;
        sb.push_back(e);
        bp = (idx + 1) % reqs_p;
        step();
        req_v_i[idx]      = 1'b0;
        req_op_i[idx]     = 4'($urandom);
        req_addrA_i[idx]  = aw'($urandom);
        req_addrB_i[idx]  = aw'($urandom);
        req_addrD_i[idx]  = aw'($urandom);
        req_scalar_i[idx] = vdw_p'($urandom);
        req_w_data_i[idx] = vw'($urandom);
        total++;
        if (vu_v_o !== ~exp_err) begin
            bad++;
            $display("FAIL issue_latency: got vu_v_o=%b one cycle after transfer, required %b", vu_v_o, ~exp_err);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", sb.size());
            sb.delete();
        end
        step();
    endtask

    task automatic test_reset();
        reset_n_i    = 1'b0;
        req_v_i      = '0;
        req_op_i     = '0;
        req_addrA_i  = '0;
        req_addrB_i  = '0;
        req_addrD_i  = '0;
        req_scalar_i = '0;
        req_w_data_i = '0;
        resp_yumi_i  = '0;
        vu_ready_i   = 1'b1;
        vu_done_i    = 1'b0;
        vu_v_i       = 1'b0;
        vu_r_data_i  = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        step();
        step();
        total++;
        if ({vu_v_o, vu_yumi_o, resp_v_o, resp_err_o} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: got v=%b yumi=%b resp_v=%b err=%b, required all 0",
                     vu_v_o, vu_yumi_o, resp_v_o, resp_err_o);
        end
        total++;
        if (resp_data_o !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h, required 0", resp_data_o);
        end
        total++;
        if ({vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o} !== '0) begin
            bad++;
            $display("FAIL reset_fields: got op=%h a=%h b=%h d=%h s=%h w=%h, required all 0",
                     vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o);
        end
        total++;
        if (req_ready_o !== '0) begin
            bad++;
            $display("FAIL reset_ready: got %b, required 00", req_ready_o);
        end
        reset_n_i = 1'b1;
        bp = 0;
        step();
    endtask

    task automatic test_back_to_back();
        int   grants = 0;
        int   n = 0;
        bit   first = 1'b1;
        logic [reqs_p-1:0] exp_g;
        exp_t e;
        req_op_i[0]     = OP_WRITE;
        req_op_i[1]     = OP_WRITE;
        req_addrD_i[0]  = 4'd1;
        req_addrD_i[1]  = 4'd2;
        req_w_data_i[0] = 24'h0A0B0C;
        req_w_data_i[1] = 24'h0D0E0F;
        req_v_i         = 2'b11;
        while (grants < 6 && n < 200) begin
            #1;
            if (req_ready_o !== '0) begin
                exp_g     = '0;
                exp_g[bp] = 1'b1;
                total++;
                if (req_ready_o !== exp_g) begin
                    bad++;
                    $display("FAIL grant_order: got %b, required %b", req_ready_o, exp_g);
                end
                if (!first) begin
                    total++;
                    if (cycle != yumi_cyc + 1) begin
                        bad++;
                        $display("FAIL grant_timing: got cycle %0d, required cycle %0d", cycle, yumi_cyc + 1);
                    end
                end
                first   = 1'b0;
                e.owner = exp_g;
                e.err   = 1'b0;
                e.data  = '0;
                e.cyc   = -2;
                sb.push_back(e);
                bp = (bp + 1) % reqs_p;
                grants++;
            end
            step();
            n++;
        end
        req_v_i = '0;
        total++;
        if (grants != 6) begin
            bad++;
            $display("FAIL back_to_back_count: got %0d grants, required 6", grants);
        end
        drain();
    endtask

    task automatic test_write_read();
        send(0, OP_WRITE, 4'd0, 4'd0, 4'd3, 6'd0, 24'h123456, 1'b0, 24'h0);
        drain();
        send(0, OP_READ, 4'd0, 4'd0, 4'd3, 6'd0, 24'h0, 1'b0, 24'h123456);
        drain();
    endtask

    task automatic test_illegal();
        int issues0 = issues;
        send(1, 4'b0011, 4'd0, 4'd0, 4'd0, 6'd0, 24'h0, 1'b1, 24'h0);
        drain();
        total++;
        if (issues != issues0) begin
            bad++;
            $display("FAIL illegal_issued: got %0d unit issues, required 0", issues - issues0);
        end
    endtask

    task automatic test_addr_bounds();
        send(0, OP_MATMUL, 4'd9,  4'd0,  4'd0,  6'd0, 24'h0, 1'b1, 24'h0);
        drain();
        send(1, OP_MATMUL, 4'd8,  4'd4,  4'd0,  6'd0, 24'h0, 1'b0, 24'h0);
        drain();
        send(0, OP_MATMUL, 4'd0,  4'd9,  4'd0,  6'd0, 24'h0, 1'b1, 24'h0);
        drain();
        send(1, OP_WRITE,  4'd15, 4'd15, 4'd11, 6'd0, 24'h00BEEF, 1'b0, 24'h0);
        drain();
        send(0, OP_READ,   4'd0,  4'd0,  4'd12, 6'd0, 24'h0, 1'b1, 24'h0);
        drain();
        send(1, OP_ADDS,   4'd0,  4'd15, 4'd0,  6'd5, 24'h0, 1'b0, 24'h0);
        drain();
        send(0, OP_ADD,    4'd0,  4'd12, 4'd0,  6'd0, 24'h0, 1'b1, 24'h0);
        drain();
    endtask

    task automatic test_backpressure();
        int hold = 0;
        int n = 0;
        int issues0 = issues;
        ready_block = 5;
        vu_ready_i  = 1'b0;
        send(0, OP_ADD, 4'd1, 4'd2, 4'd5, 6'h2A, 24'hABCDEF, 1'b0, 24'h0);
        while (vu_v_o === 1'b1 && n < 20) begin
            hold++;
            total++;
            if ({vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o} !==
                {4'b0000, 4'd1, 4'd2, 4'd5, 6'h2A, 24'hABCDEF}) begin
                bad++;
                $display("FAIL fields_hold: got op=%h a=%h b=%h d=%h s=%h w=%h, required 0 1 2 5 2a abcdef",
                         vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o);
            end
            step();
            n++;
        end
        total++;
        if (hold != 6) begin
            bad++;
            $display("FAIL backpressure_hold: got vu_v_o high %0d cycles, required 6", hold);
        end
        total++;
        if (issues != issues0 + 1) begin
            bad++;
            $display("FAIL backpressure_issue: got %0d issues, required 1", issues - issues0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        u_lat = 8;
        send(0, OP_ADD, 4'd1, 4'd2, 4'd3, 6'd1, 24'h55AA55, 1'b0, 24'h0);
        step();
        total++;
        if (vu_v_o !== 1'b0 || resp_v_o !== '0) begin
            bad++;
            $display("FAIL busy_state: got vu_v_o=%b resp_v_o=%b, required 0 and 00", vu_v_o, resp_v_o);
        end
        reset_n_i = 1'b0;
        sb.delete();
        u_busy = 1'b0;
        step();
        total++;
        if ({vu_v_o, vu_yumi_o, resp_v_o, resp_err_o, req_ready_o} !== '0 || resp_data_o !== '0 ||
            {vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got v=%b resp_v=%b err=%b op=%h d=%h w=%h, required all 0",
                     vu_v_o, resp_v_o, resp_err_o, vu_op_o, vu_addrD_o, vu_w_data_o);
        end
        reset_n_i = 1'b1;
        u_lat = 1;
        bp = 0;
        step();
        req_v_i = 2'b11;
        #1;
        total++;
        if (req_ready_o !== 2'b01) begin
            bad++;
            $display("FAIL reset_mid_pointer: got %b, required 01", req_ready_o);
        end
        req_v_i = '0;
        send(0, OP_WRITE, 4'd0, 4'd0, 4'd7, 6'd0, 24'h777777, 1'b0, 24'h0);
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_write_read();
        test_illegal();
        test_addr_bounds();
        test_backpressure();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d pending responses, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_issue_ctrl.md
# vec_issue_ctrl

Command scheduler in front of the vector unit. It shares the unit between `reqs_p` requesters using round-robin arbitration and latches each accepted command. It holds all command fields stable on the unit's input pins for the whole operation, because the unit samples `op`, addresses, scalar and write data combinationally during execution. It also screens illegal opcodes and out-of-range addresses, and routes the completion response back to the owning requester.

## Interface
- `els_p`, 12, vectors in the register file
- `vlen_p`, 4, elements per vector
- `vdw_p`, 6, bits per element
- `reqs_p`, 2, number of requesters (≥2)
- localparam `v_addr_width_lp` = `BSG_SAFE_CLOG2(els_p)`
- localparam `vw_lp` = `vlen_p*vdw_p`
- `clk_i`  in  1  sole clock
- `reset_n_i`  in  1  reset, synchronous, active-low
- `req_v_i`  in  `reqs_p`  command valid per requester
- `req_ready_o`  out  `reqs_p`  one-hot grant; a transfer occurs when `v & ready`
- `req_op_i`  in  `reqs_p`×4  opcode
- `req_addrA_i`, `req_addrB_i`, `req_addrD_i`  in  `reqs_p`×`v_addr_width_lp`  operand and destination addresses
- `req_scalar_i`  in  `reqs_p`×`vdw_p`  scalar operand
- `req_w_data_i`  in  `reqs_p`×`vw_lp`  write data
- `resp_v_o`  out  `reqs_p`  one-hot response valid
- `resp_data_o`  out  `vw_lp`  read data; 0 for non-read commands
- `resp_err_o`  out  1  command rejected, not issued
- `resp_yumi_i`  in  `reqs_p`  response consumed
- `vu_op_o`, `vu_addrA_o`, `vu_addrB_o`, `vu_addrD_o`, `vu_scalar_o`, `vu_w_data_o`  out  latched command fields
- `vu_v_o`  out  1  issue request to the unit
- `vu_ready_i`  in  1  unit idle
- `vu_done_i`  in  1  unit done pulse/level
- `vu_v_i`  in  1  read data valid
- `vu_r_data_i`  in  `vw_lp`  read data
- `vu_yumi_o`  out  1  read data consumed

## Operation
- **States:** `s_IDLE`, `s_ISSUE`, `s_BUSY`, `s_RESP`.
- **s_IDLE**
  - `req_ready_o` = round-robin grant among `req_v_i`. The priority pointer starts at 0 and moves to grant+1 (mod `reqs_p`) only on a transfer.
  - On a transfer, latch the fields and the owner index, then run the legality check.
  - Illegal → `s_RESP` with `err`=1. Legal → `s_ISSUE`.
- **Legal opcodes:** 0000, 0001, 0010, 0100, 0101, 0110, 1000, 1001, 1111. Any other opcode is illegal.
- **Address check:** widen to `v_addr_width_lp`+1 bits.
  - Every used address must be < `els_p`.
  - For op 1111, `addrA+vlen_p-1`, `addrB+vlen_p-1` and `addrD+vlen_p-1` must each be < `els_p`.
  - For read/write (1000/1001) only `addrD` is checked. For vector-scalar ops `addrB` is not checked.
- **s_ISSUE:** `vu_v_o`=1. Go to `s_BUSY` on `vu_v_o & vu_ready_i`.
- **s_BUSY:** wait for `vu_done_i`.
  - Read: data is captured when `vu_v_i`=1, with `vu_yumi_o`=1 in the same cycle.
  - Non-read: `resp_data` is cleared to 0.
  - Then go to `s_RESP`.
- **s_RESP:** `resp_v_o[owner]`=1 until `resp_yumi_i[owner]`, then go to `s_IDLE`. `resp_yumi_i` on other bits is ignored.
- **Field stability:** `vu_*` command fields are held constant from the `s_ISSUE` entry until the `s_IDLE` re-entry.

## Timing
- **Reset** (`reset_n_i`=0 at a clock edge) clears:
  - state → `s_IDLE`, pointer → 0
  - all `vu_*` fields → 0
  - `vu_v_o`, `vu_yumi_o`, `resp_v_o`, `resp_err_o` → 0
  - `resp_data_o` → 0
- **Reset mid-operation:** aborts immediately with no response. The unit's `reset_i` is tied to `~reset_n_i` at integration.
- **Issue latency:** transfer at cycle T, `vu_v_o` at T+1. If `vu_ready_i` is high, `s_BUSY` at T+2.
- **Response latency:** `resp_v_o` rises the cycle after `vu_done_i` (and `vu_v_i` for reads).
- **Rejected command:** transfer at T, `resp_v_o`+`err` at T+1.
- **No overlap:** `req_ready_o` is all-zero outside `s_IDLE`, so the next transfer happens at the earliest in the cycle after `resp_yumi_i`.
- **Back-pressure:** if `vu_ready_i`=0, the block stays in `s_ISSUE` with `vu_v_o` held high.
- **Early read data:** if `vu_v_i` arrives without `vu_done_i`, it is ignored.
- **Combinational paths:**
  - `req_ready_o` depends combinationally on `req_v_i`.
  - `vu_yumi_o` depends combinationally on `vu_v_i`.
  - No other combinational input→output paths.

## Structure
- **Package `vec_pkg`:**
  - `vec_op_e` opcode enum (`OP_ADD`…`OP_MATMUL`)
  - state enum
  - function `vec_op_legal`
- **Sub-module `vec_rr_arb`:** round-robin grant with an `advance` input, parameterised by `reqs_p`.
- The legality check and FSM stay in the top.

## Test plan
- Requester 0 writes (1001, `addrD`=3, data 0x123456); requester 0 then reads `addrD`=3 → `resp_data_o`=0x123456, `resp_v_o`=01, `err`=0.
- Both requesters valid every cycle for 6 commands → grants alternate 01,10,01,10…, each starting the cycle after the previous `resp_yumi_i`.
- Op 0011 from requester 1 → `resp_v_o`=10, `err`=1 at T+1, `vu_v_o` never asserts.
- Op 1111, `addrA`=9, `els_p`=12, `vlen_p`=4 → `err`=1. Op 1111, `addrA`=8/`addrB`=4/`addrD`=0 → issued, non-error response with data 0.
- Hold `vu_ready_i`=0 for 5 cycles in `s_ISSUE` → `vu_v_o` stays 1, all `vu_*` fields unchanged; issue occurs when ready rises.
- `reset_n_i`=0 during `s_BUSY` → next cycle all outputs are 0 and the state is `s_IDLE`; a new command is then accepted normally with the pointer at 0.
